// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Result format is {remainder, quotient}.
// Outputs are registered. ready_o rises one edge after END is entered.
// ready_o and result_o fall on the edge that leaves END.
module div_seq #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ITER   = 32
) (
    input  logic                  clk,
    input  logic                  Rst_n,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  busy_o
);

    localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int unsigned RES_W = 2 * DATA_W;

    localparam logic [1:0] ST_FREE   = 2'd0;
    localparam logic [1:0] ST_BYZERO = 2'd1;
    localparam logic [1:0] ST_ON     = 2'd2;
    localparam logic [1:0] ST_END    = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    logic [1:0]        state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [DATA_W-1:0] dvd, dvd_n;
    logic [DATA_W-1:0] dvs, dvs_n;
    logic [DATA_W-1:0] rem, rem_n;
    logic              neg_q, neg_q_n;
    logic              neg_r, neg_r_n;
    logic [RES_W-1:0]  res, res_n;
    logic [RES_W-1:0]  result_n;
    logic              ready_n;
    logic              busy_n;

    logic [DATA_W-1:0] abs1, abs2;
    logic [DATA_W:0]   trial, diff;
    logic              q_bit;
    logic [DATA_W-1:0] rem_step, dvd_step;
    logic [DATA_W-1:0] q_fix, r_fix;

    // Datapath: operand magnitudes, one restoring step, final sign fix-up.
    // dvd shifts the dividend out at the top and collects quotient bits at the bottom.
    always_comb begin
        abs1 = (signed_div_i && opdata1_i[DATA_W-1]) ? (~opdata1_i + DATA_W'(1)) : opdata1_i;
        abs2 = (signed_div_i && opdata2_i[DATA_W-1]) ? (~opdata2_i + DATA_W'(1)) : opdata2_i;
        trial    = {rem, dvd[DATA_W-1]};
        diff     = trial - {1'b0, dvs};
        q_bit    = ~diff[DATA_W];
        rem_step = q_bit ? diff[DATA_W-1:0] : trial[DATA_W-1:0];
        dvd_step = {dvd[DATA_W-2:0], q_bit};
        q_fix    = neg_q ? (~dvd_step + DATA_W'(1)) : dvd_step;
        r_fix    = neg_r ? (~rem_step + DATA_W'(1)) : rem_step;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        dvd_n    = dvd;
        dvs_n    = dvs;
        rem_n    = rem;
        neg_q_n  = neg_q;
        neg_r_n  = neg_r;
        res_n    = res;
        result_n = '0;
        ready_n  = 1'b0;

        case (state)
            ST_FREE: begin
                if (start_i && !annul_i) begin
                    dvd_n   = abs1;
                    dvs_n   = abs2;
                    rem_n   = '0;
                    cnt_n   = '0;
                    neg_q_n = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                    neg_r_n = signed_div_i & opdata1_i[DATA_W-1];
                    state_n = (opdata2_i == '0) ? ST_BYZERO : ST_ON;
                end
            end
            ST_ON: begin
                if (annul_i) begin
                    state_n = ST_FREE;
                end else begin
                    dvd_n = dvd_step;
                    rem_n = rem_step;
                    cnt_n = cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        res_n   = {r_fix, q_fix};
                        state_n = ST_END;
                    end
                end
            end
            ST_BYZERO: begin
                if (annul_i) begin
                    state_n = ST_FREE;
                end else begin
                    res_n   = '0;
                    state_n = ST_END;
                end
            end
            ST_END: begin
                if (start_i) begin
                    ready_n  = 1'b1;
                    result_n = res;
                end else begin
                    state_n = ST_FREE;
                end
            end
            default: state_n = ST_FREE;
        endcase

        busy_n = (state_n == ST_ON) || (state_n == ST_BYZERO);
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            state    <= ST_FREE;
            cnt      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            res      <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            dvd      <= dvd_n;
            dvs      <= dvs_n;
            rem      <= rem_n;
            neg_q    <= neg_q_n;
            neg_r    <= neg_r_n;
            res      <= res_n;
            result_o <= result_n;
            ready_o  <= ready_n;
            busy_o   <= busy_n;
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Testbench for div_seq.
// Directed vectors with literal expectations.
// A transaction-level reference is checked on every falling edge.
module tb_div_seq;

    logic        clk;
    logic        Rst_n;
    logic        signed_div;
    logic [31:0] opdata1, opdata2;
    logic        start, annul;
    logic [63:0] result_o;
    logic        ready_o, busy_o;

    int vectors = 0;
    int miscmp  = 0;
    bit chk_en  = 0;

    div_seq #(.DATA_W(32), .ITER(32)) dut (
        .clk         (clk),
        .Rst_n       (Rst_n),
        .signed_div_i(signed_div),
        .opdata1_i   (opdata1),
        .opdata2_i   (opdata2),
        .start_i     (start),
        .annul_i     (annul),
        .result_o    (result_o),
        .ready_o     (ready_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference quotient/remainder computed on magnitudes with plain arithmetic.
    function automatic logic [63:0] ref_div(logic [31:0] a, logic [31:0] b, logic sgn);
        longint unsigned ma, mb, q, r;
        logic na, nb;
        logic [31:0] qq, rr;
        if (b == 32'd0) return 64'd0;
        na = sgn & a[31];
        nb = sgn & b[31];
        ma = na ? (64'h1_0000_0000 - {32'd0, a}) : {32'd0, a};
        mb = nb ? (64'h1_0000_0000 - {32'd0, b}) : {32'd0, b};
        q  = ma / mb;
        r  = ma % mb;
        qq = 32'(q);
        rr = 32'(r);
        if (na ^ nb) qq = -qq;
        if (na) rr = -rr;
        return {rr, qq};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level expectation: idle, computing (cycles left), done.
    localparam int M_IDLE = 0, M_BUSY = 1, M_DONE = 2;
    int          mode = M_IDLE;
    int          cyc_left = 0;
    logic [63:0] m_res = '0;
    logic [63:0] m_out = '0;
    logic        m_ready = 1'b0;
    logic        m_busy = 1'b0;

    always @(posedge clk) begin
        if (!Rst_n) begin
            mode    = M_IDLE;
            m_ready = 1'b0;
            m_busy  = 1'b0;
            m_out   = '0;
        end else begin
            m_ready = 1'b0;
            m_out   = '0;
            case (mode)
                M_IDLE: if (start && !annul) begin
                    m_res    = ref_div(opdata1, opdata2, signed_div);
                    cyc_left = (opdata2 == 32'd0) ? 1 : 32;
                    mode     = M_BUSY;
                end
                M_BUSY: if (annul) begin
                    mode = M_IDLE;
                end else begin
                    cyc_left--;
                    if (cyc_left == 0) mode = M_DONE;
                end
                default: if (start) begin
                    m_ready = 1'b1;
                    m_out   = m_res;
                end else begin
                    mode = M_IDLE;
                end
            endcase
            m_busy = (mode == M_BUSY);
        end
    end

    // Per-cycle compare against the reference.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc ready", 64'(ready_o), 64'(m_ready));
            chk("cyc busy", 64'(busy_o), 64'(m_busy));
            chk("cyc result", result_o, m_out);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, input int exp_lat, input logic [63:0] exp_res,
                           input int hold, input bit scramble);
        int n;
        opdata1    = a;
        opdata2    = b;
        signed_div = sgn;
        start      = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            if (scramble && n == 5) begin
                opdata1    = $urandom;
                opdata2    = $urandom;
                signed_div = ~sgn;
            end
        end while (!ready_o && n < 60);
        chk({name, " latency"}, 64'(n - 1), 64'(exp_lat));
        chk({name, " result"}, result_o, exp_res);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({name, " hold result"}, result_o, exp_res);
            chk({name, " hold ready"}, 64'(ready_o), 64'd1);
        end
        start = 1'b0;
        tick();
        chk({name, " exit ready"}, 64'(ready_o), 64'd0);
        chk({name, " exit result"}, result_o, 64'd0);
        opdata1 = '0;
        opdata2 = '0;
        tick();
    endtask

    initial begin
        int n;
        Rst_n      = 1'b0;
        signed_div = 1'b0;
        opdata1    = '0;
        opdata2    = '0;
        start      = 1'b0;
        annul      = 1'b0;
        tick();
        tick();
        chk("reset result", result_o, 64'd0);
        chk("reset ready", 64'(ready_o), 64'd0);
        chk("reset busy", 64'(busy_o), 64'd0);
        Rst_n  = 1'b1;
        chk_en = 1'b1;
        tick();

        run_div("u100/7", 32'd100, 32'd7, 1'b0, 33, 64'h00000002_0000000E, 0, 0);
        run_div("s-7/2", 32'hFFFFFFF9, 32'd2, 1'b1, 33, 64'hFFFFFFFF_FFFFFFFD, 0, 0);
        run_div("uFFFFFFF9/2", 32'hFFFFFFF9, 32'd2, 1'b0, 33, 64'h00000001_7FFFFFFC, 0, 0);
        run_div("s100/-7", 32'd100, 32'hFFFFFFF9, 1'b1, 33, 64'h00000002_FFFFFFF2, 0, 0);
        run_div("5/0", 32'd5, 32'd0, 1'b0, 2, 64'd0, 5, 0);

        // Annul at iteration 10 of 1000/3, then immediate restart.
        opdata1    = 32'd1000;
        opdata2    = 32'd3;
        signed_div = 1'b0;
        start      = 1'b1;
        for (n = 0; n < 10; n++) tick();
        chk("annul busy before", 64'(busy_o), 64'd1);
        start = 1'b0;
        annul = 1'b1;
        tick();
        annul = 1'b0;
        chk("annul busy after", 64'(busy_o), 64'd0);
        chk("annul ready", 64'(ready_o), 64'd0);
        run_div("9/3 after annul", 32'd9, 32'd3, 1'b0, 33, 64'h00000000_00000003, 0, 0);

        // Signed overflow with operands scrambled while iterating.
        run_div("s80000000/-1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 33, 64'h00000000_80000000, 2, 1);

        // Synchronous reset at iteration 20.
        opdata1    = 32'd100;
        opdata2    = 32'd7;
        signed_div = 1'b0;
        start      = 1'b1;
        for (n = 0; n < 20; n++) tick();
        Rst_n = 1'b0;
        start = 1'b0;
        tick();
        chk("midreset result", result_o, 64'd0);
        chk("midreset ready", 64'(ready_o), 64'd0);
        chk("midreset busy", 64'(busy_o), 64'd0);
        Rst_n = 1'b1;
        tick();
        run_div("u2000/9", 32'd2000, 32'd9, 1'b0, 33, 64'h00000002_000000DE, 0, 0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
        $finish;
    end

endmodule
